// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes host command bytes from the UART receiver into
// SD driver write/read block requests plus a BLOCK_LEN-byte payload stream.
// Command: opcode ('W' 0x57 or 'R' 0x52), then a 4-byte block address, MSB first.
// Optional build macro CMD_TIMEOUT_EN adds an inter-byte timeout that abandons
// a partial command or payload after TIMEOUT_CYCLES idle clocks.
module uart_cmd_parser #(
    parameter int BLOCK_LEN      = 512,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DAT,
    output logic        RX_ACK,
    output logic        WR_STB,
    output logic [31:0] WR_ADDR,
    input  logic        WR_ACK,
    output logic        WD_STB,
    output logic [7:0]  WD_DATA,
    input  logic        WD_ACK,
    output logic        RD_STB,
    output logic [31:0] RD_ADDR,
    input  logic        RD_ACK,
    output logic        BUSY,
    output logic [7:0]  ERR_CNT
);

    localparam int             DCW   = $clog2(BLOCK_LEN) + 1;
    localparam logic [DCW-1:0] DLAST = DCW'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ISSUE_WR,
        ISSUE_RD,
        DATA_GET,
        DATA_PUT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       addr_cnt_q, addr_cnt_d;
    logic [DCW-1:0]   data_cnt_q, data_cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [7:0]       wd_data_q, wd_data_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             rx_ack_q, rx_ack_d;
    logic             wr_stb_q, wr_stb_d;
    logic             rd_stb_q, rd_stb_d;
    logic             wd_stb_q, wd_stb_d;
    logic             accept;
    logic             err_inc;
    logic             tmo_fire;

    // A byte moves only when our registered ack meets the host strobe.
    assign accept = RX_STB && rx_ack_q;

`ifdef CMD_TIMEOUT_EN
    localparam int               TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Idle counter: runs only while waiting for a host byte, restarts on each byte.
    always_comb begin
        tmo_d    = '0;
        tmo_fire = 1'b0;
        if ((state_q == ADDR || state_q == DATA_GET) && !accept) begin
            if (tmo_q == TMO_MAX) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_param;
    assign unused_tmo_param = (TIMEOUT_CYCLES > 0);
    assign tmo_fire         = 1'b0;
`endif

    // Next-state and datapath decode; strobes are derived from the next state so
    // they are registered and stay up exactly as long as the issuing state lasts.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_cnt_d = addr_cnt_q;
        data_cnt_d = data_cnt_q;
        op_wr_d    = op_wr_q;
        wd_data_d  = wd_data_q;
        err_cnt_d  = err_cnt_q;
        err_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (RX_DAT == 8'h57 || RX_DAT == 8'h52) begin
                        op_wr_d    = (RX_DAT == 8'h57);
                        addr_cnt_d = 2'd0;
                        state_d    = ADDR;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_d     = {addr_q[23:0], RX_DAT};
                    addr_cnt_d = addr_cnt_q + 2'd1;
                    if (addr_cnt_q == 2'd3) begin
                        state_d = op_wr_q ? ISSUE_WR : ISSUE_RD;
                    end
                end
            end
            ISSUE_WR: begin
                if (WR_ACK && wr_stb_q) begin
                    data_cnt_d = '0;
                    state_d    = DATA_GET;
                end
            end
            ISSUE_RD: begin
                if (RD_ACK && rd_stb_q) begin
                    state_d = IDLE;
                end
            end
            DATA_GET: begin
                if (accept) begin
                    wd_data_d = RX_DAT;
                    state_d   = DATA_PUT;
                end
            end
            DATA_PUT: begin
                if (WD_ACK && wd_stb_q) begin
                    data_cnt_d = data_cnt_q + DCW'(1);
                    state_d    = (data_cnt_q == DLAST) ? IDLE : DATA_GET;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout wins over everything: the partial command is simply dropped.
        if (tmo_fire) begin
            state_d = IDLE;
            err_inc = 1'b1;
        end

        if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        wr_stb_d = (state_d == ISSUE_WR);
        rd_stb_d = (state_d == ISSUE_RD);
        wd_stb_d = (state_d == DATA_PUT);
        // Ack only a waiting byte, only in a byte-taking state, never two cycles running.
        rx_ack_d = RX_STB && !rx_ack_q &&
                   (state_d == IDLE || state_d == ADDR || state_d == DATA_GET);
    end

    // State and output registers.
    always_ff @(posedge CLOCK50 or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            addr_cnt_q <= '0;
            data_cnt_q <= '0;
            op_wr_q    <= 1'b0;
            wd_data_q  <= '0;
            err_cnt_q  <= '0;
            rx_ack_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            wd_stb_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            addr_cnt_q <= addr_cnt_d;
            data_cnt_q <= data_cnt_d;
            op_wr_q    <= op_wr_d;
            wd_data_q  <= wd_data_d;
            err_cnt_q  <= err_cnt_d;
            rx_ack_q   <= rx_ack_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            wd_stb_q   <= wd_stb_d;
        end
    end

    assign RX_ACK  = rx_ack_q;
    assign WR_STB  = wr_stb_q;
    assign RD_STB  = rd_stb_q;
    assign WD_STB  = wd_stb_q;
    assign WR_ADDR = addr_q;
    assign RD_ADDR = addr_q;
    assign WD_DATA = wd_data_q;
    assign ERR_CNT = err_cnt_q;
    assign BUSY    = (state_q != IDLE);

endmodule
